// File: rtl/regfile_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_ctrl_pkg
// Description : Shared types and constants for the register-file write-port
//               controller (state encoding, register count, address width).
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_ctrl_pkg;

  localparam int NREG    = 32;
  localparam int RADDR_W = 5;

  typedef enum logic [1:0] {
    RESET    = 2'd0,
    CLEAR    = 2'd1,
    RUN      = 2'd2,
    DBG_SLOT = 2'd3
  } rfc_state_e;

endpackage : regfile_ctrl_pkg
`default_nettype wire

// File: rtl/regfile_wr_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wr_ctrl
// Description : Write-port controller for the integer register file. Clears
//               x1..x31 after reset, then arbitrates the single write port
//               between writeback (priority) and a debug/loader requester
//               with a starvation bound that forces a debug slot.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wr_ctrl
  import regfile_ctrl_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int DBG_STARVE_MAX = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wb_we,
  input  logic [4:0]         wb_rd,
  input  logic [XLEN-1:0]    wb_wd,
  input  logic               dbg_valid,
  input  logic [4:0]         dbg_rd,
  input  logic [XLEN-1:0]    dbg_wd,
  output logic               dbg_ready,
  output logic               wb_stall,
  output logic               init_done,
  output logic               rf_we3,
  output logic [4:0]         rf_a3,
  output logic [XLEN-1:0]    rf_wd3
);

  localparam int                  SW          = $clog2(DBG_STARVE_MAX + 1);
  localparam logic [SW-1:0]       STARVE_LAST = SW'(DBG_STARVE_MAX - 1);
  localparam logic [RADDR_W-1:0]  CLR_LAST    = RADDR_W'(NREG - 1);

  rfc_state_e          state_q, state_d;
  logic [RADDR_W-1:0]  clr_cnt_q, clr_cnt_d;
  logic [SW-1:0]       starve_cnt_q, starve_cnt_d;
  logic                wb_stall_q, wb_stall_d;
  logic                init_done_q, init_done_d;

  logic                dbg_blocked;
  logic                sel_we;
  logic [RADDR_W-1:0]  sel_a;
  logic [XLEN-1:0]     sel_wd;

  // Debug is blocked only while writeback owns the port in RUN
  assign dbg_blocked = dbg_valid & wb_we;

  // Next-state logic: clear sequencing, starvation tracking, state-decoded flags
  always_comb begin
    state_d      = state_q;
    clr_cnt_d    = clr_cnt_q;
    starve_cnt_d = starve_cnt_q;
    case (state_q)
      RESET: begin
        state_d      = CLEAR;
        clr_cnt_d    = RADDR_W'(1);
        starve_cnt_d = '0;
      end
      CLEAR: begin
        clr_cnt_d = clr_cnt_q + RADDR_W'(1);
        if (clr_cnt_q == CLR_LAST) begin
          state_d = RUN;
        end
      end
      RUN: begin
        // Any cycle that is not blocked is either a transfer or an idle
        // requester; both restart the starvation window.
        if (dbg_blocked) begin
          starve_cnt_d = starve_cnt_q + SW'(1);
          if (starve_cnt_q == STARVE_LAST) begin
            state_d = DBG_SLOT;
          end
        end else begin
          starve_cnt_d = '0;
        end
      end
      DBG_SLOT: begin
        state_d      = RUN;
        starve_cnt_d = '0;
      end
      default: begin
        state_d = RESET;
      end
    endcase
    // Flags depend on state only, so they are registered from the next state
    wb_stall_d  = (state_d != RUN);
    init_done_d = (state_d == RUN) || (state_d == DBG_SLOT);
  end

  // State and counter registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RESET;
      clr_cnt_q    <= '0;
      starve_cnt_q <= '0;
      wb_stall_q   <= 1'b1;
      init_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      starve_cnt_q <= starve_cnt_d;
      wb_stall_q   <= wb_stall_d;
      init_done_q  <= init_done_d;
    end
  end

  // Write-port source select and debug handshake, combinational from state + inputs
  always_comb begin
    sel_we    = 1'b0;
    sel_a     = '0;
    sel_wd    = '0;
    dbg_ready = 1'b0;
    case (state_q)
      CLEAR: begin
        sel_we = 1'b1;
        sel_a  = clr_cnt_q;
      end
      RUN: begin
        if (wb_we) begin
          sel_we = 1'b1;
          sel_a  = wb_rd;
          sel_wd = wb_wd;
        end else if (dbg_valid) begin
          sel_we    = 1'b1;
          sel_a     = dbg_rd;
          sel_wd    = dbg_wd;
          dbg_ready = 1'b1;
        end
      end
      DBG_SLOT: begin
        // A request that vanished here is a protocol violation: no write
        dbg_ready = 1'b1;
        sel_we    = dbg_valid;
        sel_a     = dbg_rd;
        sel_wd    = dbg_wd;
      end
      default: begin
        sel_we = 1'b0;
      end
    endcase
  end

  // x0 is hardwired zero, and an idle port drives zeros for clean traces
  assign rf_we3 = sel_we & (sel_a != '0);
  assign rf_a3  = rf_we3 ? sel_a  : '0;
  assign rf_wd3 = rf_we3 ? sel_wd : '0;

  assign wb_stall  = wb_stall_q;
  assign init_done = init_done_q;

endmodule : regfile_wr_ctrl
`default_nettype wire

// File: tb/tb_regfile_wr_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_wr_ctrl
// Description : Directed self-checking bench for regfile_wr_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wr_ctrl;

  localparam int XLEN = 32;

  logic            clk;
  logic            rst_n;
  logic            wb_we;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_wd;
  logic            dbg_valid;
  logic [4:0]      dbg_rd;
  logic [XLEN-1:0] dbg_wd;
  logic            dbg_ready;
  logic            wb_stall;
  logic            init_done;
  logic            rf_we3;
  logic [4:0]      rf_a3;
  logic [XLEN-1:0] rf_wd3;

  int n_checks = 0;
  int n_fail   = 0;

  regfile_wr_ctrl #(.XLEN(XLEN), .DBG_STARVE_MAX(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wb_we     (wb_we),
    .wb_rd     (wb_rd),
    .wb_wd     (wb_wd),
    .dbg_valid (dbg_valid),
    .dbg_rd    (dbg_rd),
    .dbg_wd    (dbg_wd),
    .dbg_ready (dbg_ready),
    .wb_stall  (wb_stall),
    .init_done (init_done),
    .rf_we3    (rf_we3),
    .rf_a3     (rf_a3),
    .rf_wd3    (rf_wd3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Port view packed as {we3, a3, wd3} and flags as {dbg_ready, wb_stall, init_done}
  function automatic logic [37:0] port_v();
    return {rf_we3, rf_a3, rf_wd3};
  endfunction
  function automatic logic [2:0] flag_v();
    return {dbg_ready, wb_stall, init_done};
  endfunction

  task automatic idle_inputs();
    wb_we = 1'b0; wb_rd = '0; wb_wd = '0;
    dbg_valid = 1'b0; dbg_rd = '0; dbg_wd = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if (port_v() !== 38'd0 || flag_v() !== 3'b010) begin
      n_fail++;
      $display("FAIL reset_hold: port=%h flags=%b expected port=0 flags=010", port_v(), flag_v());
    end
    // Release at a negedge; hold a debug request to verify it is ignored during clear
    @(negedge clk);
    rst_n = 1'b1;
    dbg_valid = 1'b1; dbg_rd = 5'd7; dbg_wd = 32'h5555_AAAA;
    #1;
    n_checks++;
    if (port_v() !== 38'd0 || flag_v() !== 3'b010) begin
      n_fail++;
      $display("FAIL reset_state: port=%h flags=%b expected port=0 flags=010", port_v(), flag_v());
    end
    for (int i = 1; i <= 31; i++) begin
      @(negedge clk);
      if (i == 31) dbg_valid = 1'b0;
      #1;
      n_checks++;
      if (port_v() !== {1'b1, 5'(i), 32'd0} || flag_v() !== 3'b010) begin
        n_fail++;
        $display("FAIL clear_cycle_%0d: port=%h flags=%b expected port=%h flags=010",
                 i, port_v(), flag_v(), {1'b1, 5'(i), 32'd0});
      end
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (flag_v() !== 3'b001 || port_v() !== 38'd0) begin
      n_fail++;
      $display("FAIL init_done_cycle32: flags=%b port=%h expected flags=001 port=0", flag_v(), port_v());
    end
  endtask

  task automatic test_wb_write();
    @(negedge clk);
    idle_inputs();
    wb_we = 1'b1; wb_rd = 5'd5; wb_wd = 32'hDEAD_BEEF;
    #1;
    n_checks++;
    if (port_v() !== {1'b1, 5'd5, 32'hDEAD_BEEF} || flag_v() !== 3'b001) begin
      n_fail++;
      $display("FAIL wb_write: port=%h flags=%b expected port=%h flags=001",
               port_v(), flag_v(), {1'b1, 5'd5, 32'hDEAD_BEEF});
    end
    @(negedge clk);
    idle_inputs();
    #1;
    n_checks++;
    if (port_v() !== 38'd0 || flag_v() !== 3'b001) begin
      n_fail++;
      $display("FAIL idle_port: port=%h flags=%b expected port=0 flags=001", port_v(), flag_v());
    end
  endtask

  task automatic test_dbg_write();
    @(negedge clk);
    idle_inputs();
    dbg_valid = 1'b1; dbg_rd = 5'd10; dbg_wd = 32'h0000_1234;
    #1;
    n_checks++;
    if (port_v() !== {1'b1, 5'd10, 32'h1234} || flag_v() !== 3'b101) begin
      n_fail++;
      $display("FAIL dbg_write: port=%h flags=%b expected port=%h flags=101",
               port_v(), flag_v(), {1'b1, 5'd10, 32'h1234});
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_starvation();
    // Four blocked cycles, forced slot on the fifth, writeback resumes on the sixth
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      wb_we = 1'b1; wb_rd = 5'(c + 1); wb_wd = 32'(c * 16'h0101);
      dbg_valid = (c <= 5); dbg_rd = 5'd20; dbg_wd = 32'h0000_CAFE;
      #1;
      n_checks++;
      if (c <= 4 || c == 6) begin
        if (port_v() !== {1'b1, 5'(c + 1), 32'(c * 16'h0101)} || flag_v() !== 3'b001) begin
          n_fail++;
          $display("FAIL starve_wb_cycle_%0d: port=%h flags=%b expected port=%h flags=001",
                   c, port_v(), flag_v(), {1'b1, 5'(c + 1), 32'(c * 16'h0101)});
        end
      end else begin
        if (port_v() !== {1'b1, 5'd20, 32'h0000_CAFE} || flag_v() !== 3'b111) begin
          n_fail++;
          $display("FAIL starve_slot: port=%h flags=%b expected port=%h flags=111",
                   port_v(), flag_v(), {1'b1, 5'd20, 32'h0000_CAFE});
        end
      end
    end
    n_checks++;
    if (dut.starve_cnt_q !== '0) begin
      n_fail++;
      $display("FAIL starve_cnt_after_slot: got %0d expected 0", dut.starve_cnt_q);
    end
    // A gap in the request restarts the window: three blocked cycles stay unserved
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      wb_we = 1'b1; wb_rd = 5'd3; wb_wd = 32'h11;
      dbg_valid = 1'b1; dbg_rd = 5'd21; dbg_wd = 32'h22;
      #1;
      n_checks++;
      if (dbg_ready !== 1'b0 || wb_stall !== 1'b0) begin
        n_fail++;
        $display("FAIL starve_window_%0d: dbg_ready=%b wb_stall=%b expected 0 0", c, dbg_ready, wb_stall);
      end
    end
    @(negedge clk);
    dbg_valid = 1'b0;
    #1;
    // Four more blocked cycles, then the slot in which the request is withdrawn
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      wb_we = 1'b1; wb_rd = 5'd3; wb_wd = 32'h11;
      dbg_valid = (c <= 4); dbg_rd = 5'd21; dbg_wd = 32'h22;
      #1;
      n_checks++;
      if (c <= 4) begin
        if (dbg_ready !== 1'b0 || wb_stall !== 1'b0) begin
          n_fail++;
          $display("FAIL restart_block_%0d: dbg_ready=%b wb_stall=%b expected 0 0", c, dbg_ready, wb_stall);
        end
      end else begin
        if (port_v() !== 38'd0 || wb_stall !== 1'b1) begin
          n_fail++;
          $display("FAIL slot_dropped: port=%h wb_stall=%b expected port=0 wb_stall=1", port_v(), wb_stall);
        end
      end
    end
    @(negedge clk);
    idle_inputs();
    #1;
    n_checks++;
    if (flag_v() !== 3'b001) begin
      n_fail++;
      $display("FAIL after_dropped_slot: flags=%b expected 001", flag_v());
    end
  endtask

  task automatic test_x0();
    @(negedge clk);
    idle_inputs();
    wb_we = 1'b1; wb_rd = 5'd0; wb_wd = 32'hFFFF_FFFF;
    #1;
    n_checks++;
    if (port_v() !== 38'd0 || dbg_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL wb_x0: port=%h dbg_ready=%b expected port=0 dbg_ready=0", port_v(), dbg_ready);
    end
    @(negedge clk);
    idle_inputs();
    dbg_valid = 1'b1; dbg_rd = 5'd0; dbg_wd = 32'h0BAD_0BAD;
    #1;
    n_checks++;
    if (port_v() !== 38'd0 || dbg_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL dbg_x0: port=%h dbg_ready=%b expected port=0 dbg_ready=1", port_v(), dbg_ready);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_reset_mid_clear();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 17; i++) @(negedge clk);
    #1;
    n_checks++;
    if (port_v() !== {1'b1, 5'd17, 32'd0}) begin
      n_fail++;
      $display("FAIL pre_pulse_clr17: port=%h expected %h", port_v(), {1'b1, 5'd17, 32'd0});
    end
    // Asynchronous pulse mid-cycle, with a debug request pending
    dbg_valid = 1'b1; dbg_rd = 5'd9; dbg_wd = 32'h99;
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if (port_v() !== 38'd0 || flag_v() !== 3'b010) begin
      n_fail++;
      $display("FAIL mid_clear_reset: port=%h flags=%b expected port=0 flags=010", port_v(), flag_v());
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int i = 1; i <= 31; i++) begin
      @(negedge clk);
      #1;
      n_checks++;
      if (port_v() !== {1'b1, 5'(i), 32'd0} || flag_v() !== 3'b010) begin
        n_fail++;
        $display("FAIL reclear_cycle_%0d: port=%h flags=%b expected port=%h flags=010",
                 i, port_v(), flag_v(), {1'b1, 5'(i), 32'd0});
      end
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (flag_v() !== 3'b101 || port_v() !== {1'b1, 5'd9, 32'h99}) begin
      n_fail++;
      $display("FAIL reclear_done: flags=%b port=%h expected flags=101 port=%h",
               flag_v(), port_v(), {1'b1, 5'd9, 32'h99});
    end
    @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_wb_write();
    test_dbg_write();
    test_starvation();
    test_x0();
    test_reset_mid_clear();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_regfile_wr_ctrl
`default_nettype wire
